// File: rtl/uc_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit.
package uc_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    WB_R   = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    WB_LW  = 4'd6,
    MEM_WR = 4'd7,
    BRANCH = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01
  } pc_src_t;

  typedef enum logic [2:0] {
    OPC_R,
    OPC_LD,
    OPC_ST,
    OPC_BEQ,
    OPC_ILLEGAL
  } op_class_t;

  // States that hold a memory request open and are policed by the wait timer.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/uc_multicycle_if.sv
// Control-unit to datapath/memory bundle: opcode and status in, strobes out.
interface uc_multicycle_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
);
  logic [OP_W-1:0]    op;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               ir_write;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_src;
  logic               illegal_op;
  logic               bus_err;
  logic [3:0]         state_o;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
           illegal_op, bus_err, state_o
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
           illegal_op, bus_err, state_o
  );
endinterface

// File: rtl/uc_mem_wait_timer.sv
// Counts unanswered memory-request cycles and flags the last allowed one.
module uc_mem_wait_timer #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  input  logic ready,
  output logic timeout
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_reg;

  // A ready in the threshold cycle still wins over the timeout.
  assign timeout = count_en && !ready && (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (count_en && !ready) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/uc_multicycle.sv
// Multi-cycle MIPS control FSM with memory handshake timeout and opcode trap.
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int ALUOP_W     = 3,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  uc_multicycle_if.master  bus
);
  state_t        state_reg;
  state_t        state_next;
  op_class_t     op_class;
  logic          in_mem;
  logic          timeout;
  logic          timer_clear;

  logic               pc_write;
  logic               ir_write;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_src;
  logic               illegal_op;
  logic               bus_err;

  always_comb begin
    op_class = OPC_ILLEGAL;
    if (bus.op == OP_W'(OP_RTYPE) || bus.op == OP_W'(OP_SPECIAL2)) begin
      op_class = OPC_R;
    end else if (bus.op == OP_W'(OP_LW)) begin
      op_class = OPC_LD;
    end else if (bus.op == OP_W'(OP_SW)) begin
      op_class = OPC_ST;
    end else if (bus.op == OP_W'(OP_BEQ)) begin
      op_class = OPC_BEQ;
    end
  end

  assign in_mem = is_mem_state(state_reg);
  // Counter idles at zero outside memory states, so every entry starts fresh.
  assign timer_clear = !in_mem || bus.mem_ready || timeout;

  uc_mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .count_en (in_mem),
    .ready    (bus.mem_ready),
    .timeout  (timeout)
  );

  always_comb begin
    state_next = state_reg;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALUOP_W'(ALU_ADD);
    pc_src     = PCSRC_ALU;
    illegal_op = 1'b0;
    bus_err    = 1'b0;

    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          bus_err    = 1'b1;
          state_next = FETCH;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (op_class)
          OPC_R:          state_next = EXEC_R;
          OPC_LD, OPC_ST: state_next = ADDR;
          OPC_BEQ:        state_next = BRANCH;
          default: begin
            illegal_op = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_W'(ALU_FUNCT);
        state_next = WB_R;
      end
      WB_R: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        // A non-memory opcode here means the IR changed under us; abandon safely.
        case (op_class)
          OPC_LD:  state_next = MEM_RD;
          OPC_ST:  state_next = MEM_WR;
          default: state_next = FETCH;
        endcase
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) begin
          state_next = WB_LW;
        end else if (timeout) begin
          bus_err    = 1'b1;
          state_next = FETCH;
        end
      end
      WB_LW: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) begin
          state_next = FETCH;
        end else if (timeout) begin
          bus_err    = 1'b1;
          state_next = FETCH;
        end
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_W'(ALU_SUB);
        pc_src     = PCSRC_ALUOUT;
        pc_write   = bus.zero;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Strobes are forced quiet while reset is held, even mid-access.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      alu_op     = '0;
      pc_src     = PCSRC_ALU;
      illegal_op = 1'b0;
      bus_err    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.iord       = iord;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_dst    = reg_dst;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_src     = pc_src;
  assign bus.illegal_op = illegal_op;
  assign bus.bus_err    = bus_err;
  assign bus.state_o    = state_reg;
endmodule

// File: tb/tb_uc_multicycle.sv
// Directed-vector scoreboard bench for the multi-cycle control unit.
module tb_uc_multicycle;
  import uc_pkg::*;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [18:0] ctl;
  } exp_t;

  function automatic logic [18:0] ctl(
    input logic pcw, irw, io, mr, mw, m2r, rd, rw, asa,
    input logic [1:0] asb, input logic [2:0] aop, input logic [1:0] pcs,
    input logic ill, be);
    return {pcw, irw, io, mr, mw, m2r, rd, rw, asa, asb, aop, pcs, ill, be};
  endfunction

  localparam logic [18:0] C_ZERO   = 19'd0;
  localparam logic [18:0] C_FW     = ctl(0,0,0,1,0,0,0,0,0,2'b01,3'b000,2'b00,0,0);
  localparam logic [18:0] C_FR     = ctl(1,1,0,1,0,0,0,0,0,2'b01,3'b000,2'b00,0,0);
  localparam logic [18:0] C_DEC    = ctl(0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0,0);
  localparam logic [18:0] C_ILL    = ctl(0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,1,0);
  localparam logic [18:0] C_EXR    = ctl(0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0);
  localparam logic [18:0] C_WBR    = ctl(0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,0);
  localparam logic [18:0] C_ADDR   = ctl(0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,0);
  localparam logic [18:0] C_MRD    = ctl(0,0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0);
  localparam logic [18:0] C_WBLW   = ctl(0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,0);
  localparam logic [18:0] C_MWR    = ctl(0,0,1,0,1,0,0,0,0,2'b00,3'b000,2'b00,0,0);
  localparam logic [18:0] C_MWR_TO = ctl(0,0,1,0,1,0,0,0,0,2'b00,3'b000,2'b00,0,1);
  localparam logic [18:0] C_BR1    = ctl(1,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0,0);
  localparam logic [18:0] C_BR0    = ctl(0,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0,0);
  localparam logic [5:0]  J        = 6'h2A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  uc_multicycle_if #(.OP_W(6), .ALUOP_W(3)) bus ();

  uc_multicycle #(
    .OP_W(6), .ALUOP_W(3), .TIMEOUT_CYC(16), .CNT_W(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input string name, input logic r, input logic [5:0] o,
                      input logic z, input logic rdy, input state_t st,
                      input logic [18:0] c);
    exp_t e;
    rst_n         = r;
    bus.op        = o;
    bus.zero      = z;
    bus.mem_ready = rdy;
    e.name = name;
    e.st   = st;
    e.ctl  = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the DUT's outputs mid-cycle against the queued expectation.
  initial begin
    exp_t        e;
    logic [18:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = ctl(bus.pc_write, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
                  bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal_op, bus.bus_err);
        n_vec++;
        if (act !== e.ctl || bus.state_o !== e.st) begin
          n_err++;
          $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                   e.name, bus.state_o, act, e.st, e.ctl);
        end else begin
          $display("ok   %s: state=%0d ctl=%b", e.name, bus.state_o, act);
        end
      end
    end
  end

  initial begin
    bus.op = J;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("rst_hold_a", 0, J, 0, 1, FETCH, C_ZERO);
    step("rst_hold_b", 0, J, 0, 1, FETCH, C_ZERO);
    step("rst_release", 1, J, 0, 0, FETCH, C_FW);

    step("r_fetch",  1, J,        0, 1, FETCH,  C_FR);
    step("r_decode", 1, OP_RTYPE, 0, 1, DECODE, C_DEC);
    step("r_exec",   1, OP_RTYPE, 0, 1, EXEC_R, C_EXR);
    step("r_wb",     1, J,        0, 1, WB_R,   C_WBR);

    step("mul_fetch",  1, J,           0, 1, FETCH,  C_FR);
    step("mul_decode", 1, OP_SPECIAL2, 0, 1, DECODE, C_DEC);
    step("mul_exec",   1, OP_SPECIAL2, 0, 1, EXEC_R, C_EXR);
    step("mul_wb",     1, J,           0, 1, WB_R,   C_WBR);

    step("lw_fetch",  1, J,     0, 1, FETCH,  C_FR);
    step("lw_decode", 1, OP_LW, 0, 1, DECODE, C_DEC);
    step("lw_addr",   1, OP_LW, 0, 1, ADDR,   C_ADDR);
    for (int i = 0; i < 3; i++) step("lw_mem_wait", 1, J, 0, 0, MEM_RD, C_MRD);
    step("lw_mem_rdy", 1, J, 0, 1, MEM_RD, C_MRD);
    step("lw_wb",      1, J, 0, 1, WB_LW,  C_WBLW);

    step("sw_fetch",  1, J,     0, 1, FETCH,  C_FR);
    step("sw_decode", 1, OP_SW, 0, 1, DECODE, C_DEC);
    step("sw_addr",   1, OP_SW, 0, 1, ADDR,   C_ADDR);
    step("sw_mem",    1, J,     0, 1, MEM_WR, C_MWR);

    step("beq1_fetch",  1, J,      1, 1, FETCH,  C_FR);
    step("beq1_decode", 1, OP_BEQ, 1, 1, DECODE, C_DEC);
    step("beq1_branch", 1, J,      1, 1, BRANCH, C_BR1);
    step("beq0_fetch",  1, J,      0, 1, FETCH,  C_FR);
    step("beq0_decode", 1, OP_BEQ, 0, 1, DECODE, C_DEC);
    step("beq0_branch", 1, J,      0, 1, BRANCH, C_BR0);

    step("to_fetch",  1, J,     0, 1, FETCH,  C_FR);
    step("to_decode", 1, OP_SW, 0, 1, DECODE, C_DEC);
    step("to_addr",   1, OP_SW, 0, 1, ADDR,   C_ADDR);
    for (int i = 0; i < 15; i++) step("to_wait", 1, J, 0, 0, MEM_WR, C_MWR);
    step("to_bus_err",  1, J, 0, 0, MEM_WR, C_MWR_TO);
    step("to_recover",  1, J, 0, 0, FETCH,  C_FW);

    step("late_fetch",  1, J,     0, 1, FETCH,  C_FR);
    step("late_decode", 1, OP_SW, 0, 1, DECODE, C_DEC);
    step("late_addr",   1, OP_SW, 0, 1, ADDR,   C_ADDR);
    for (int i = 0; i < 15; i++) step("late_wait", 1, J, 0, 0, MEM_WR, C_MWR);
    step("late_rdy16", 1, J, 0, 1, MEM_WR, C_MWR);
    step("late_done",  1, J, 0, 0, FETCH,  C_FW);

    step("ill_fetch",  1, J,     0, 1, FETCH,  C_FR);
    step("ill_decode", 1, 6'h3F, 0, 1, DECODE, C_ILL);
    step("ill_next",   1, J,     0, 0, FETCH,  C_FW);

    step("mid_fetch",  1, J,     0, 1, FETCH,  C_FR);
    step("mid_decode", 1, OP_SW, 0, 1, DECODE, C_DEC);
    step("mid_addr",   1, OP_SW, 0, 1, ADDR,   C_ADDR);
    step("mid_wait",   1, J,     0, 0, MEM_WR, C_MWR);
    step("mid_reset",  0, J,     0, 0, MEM_WR, C_ZERO);
    step("mid_after",  1, J,     0, 0, FETCH,  C_FW);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
